// File: rtl/vec_seq_pkg.sv
// Shared state encoding, force-format codes and helpers for vector_sequencer.
package vec_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] FF_R0     = 2'b00;
  localparam logic [1:0] FF_R1     = 2'b01;
  localparam logic [1:0] FF_DNRZ_L = 2'b10;
  localparam logic [1:0] FF_DNRZ_T = 2'b11;
  localparam logic [1:0] FF_RST    = FF_R0;

  // A programmed length of zero behaves as one clock per tester cycle.
  function automatic logic [7:0] eff_len(input logic [7:0] len);
    return (len == 8'd0) ? 8'd1 : len;
  endfunction

endpackage

// File: rtl/vec_fifo.sv
// Synchronous vector FIFO: pop data is the combinational head, full is registered from next occupancy.
// Flush dominates push/pop in the same clock; push when full and pop when empty are ignored.
module vec_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count_nxt;
  logic             do_push, do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign empty   = (count == '0);
  assign pop_dat = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_nxt = count + (AW+1)'(1);
        2'b01:   count_nxt = count - (AW+1)'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/vector_sequencer.sv
// vector_sequencer: buffers host vectors and applies one per tester cycle, 1 clock from pop to outputs.
// VEC_READY backpressures the host when the FIFO is full; VEC_SEQ_UNDERRUN_HOLD_EN holds the vector on underrun.
module vector_sequencer
  import vec_seq_pkg::*;
#(
  parameter int NPINS = 8,
  parameter int DEPTH = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               STOP,
  input  logic [7:0]         CYCLE_LENGTH,
  input  logic               VEC_VALID,
  output logic               VEC_READY,
  input  logic [NPINS-1:0]   VEC_DATA,
  input  logic [2*NPINS-1:0] VEC_FF,
  input  logic               VEC_LAST,
  output logic [NPINS-1:0]   D_OUT,
  output logic [2*NPINS-1:0] FF_OUT,
  output logic               EN_OUT,
  output logic               BUSY,
  output logic               DONE,
  output logic               UNDERRUN,
  output logic [15:0]        VEC_COUNT
);

  localparam int W  = 3*NPINS + 1;
  localparam int CW = $clog2(DEPTH) + 1;

  state_t        state, state_nxt;
  logic [7:0]    cyc_cnt, cyc_len;
  logic          last_q, rdy_q;
  logic          pop, underrun_evt, boundary;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_level_unused;
  logic [W-1:0]  head;

  vec_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .flush    (STOP),
    .push     (VEC_VALID && VEC_READY),
    .push_dat ({VEC_LAST, VEC_FF, VEC_DATA}),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_level_unused)
  );

  // rdy_q keeps VEC_READY low until the first clock after reset release.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rdy_q <= 1'b0;
    else     rdy_q <= 1'b1;
  end
  assign VEC_READY = rdy_q && !fifo_full;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  assign boundary = (state == ST_RUN) && (cyc_cnt == cyc_len);

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    underrun_evt = 1'b0;
    if (STOP) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (START) state_nxt = ST_PRIME;
        ST_PRIME: if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_RUN;
                  end
        ST_RUN:   if (boundary) begin
                    if (last_q) begin
                      state_nxt = ST_DONE;
                    end else if (!fifo_empty) begin
                      pop = 1'b1;
                    end else begin
                      underrun_evt = 1'b1;
`ifdef VEC_SEQ_UNDERRUN_HOLD_EN
                      state_nxt = ST_RUN;
`else
                      state_nxt = ST_IDLE;
`endif
                    end
                  end
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    EN_OUT = (state == ST_RUN);
    BUSY   = (state != ST_IDLE);
    DONE   = (state == ST_DONE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      D_OUT     <= '0;
      FF_OUT    <= {NPINS{FF_RST}};
      last_q    <= 1'b0;
      cyc_cnt   <= 8'd0;
      cyc_len   <= 8'd1;
      VEC_COUNT <= 16'd0;
      UNDERRUN  <= 1'b0;
    end else begin
      if (state == ST_IDLE && START && !STOP) begin
        VEC_COUNT <= 16'd0;
        UNDERRUN  <= 1'b0;
      end
      if (pop) begin
        D_OUT   <= head[NPINS-1:0];
        FF_OUT  <= head[3*NPINS-1:NPINS];
        last_q  <= head[W-1];
        cyc_cnt <= 8'd1;
        cyc_len <= eff_len(CYCLE_LENGTH);
        if (VEC_COUNT != 16'hFFFF) VEC_COUNT <= VEC_COUNT + 16'd1;
      end else if (underrun_evt) begin
        // In hold mode the current vector gets a fresh tester cycle.
        UNDERRUN <= 1'b1;
        cyc_cnt  <= 8'd1;
        cyc_len  <= eff_len(CYCLE_LENGTH);
      end else if (state == ST_RUN) begin
        cyc_cnt <= cyc_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/vector_sequencer.md
# vector_sequencer

Upstream pattern stage of the ASIC tester pin path. Accepts test vectors from the host over a valid/ready stream, buffers them in a small FIFO, and presents one vector per tester cycle (CYCLE_LENGTH clocks) to the per-pin force-format registers as data bits plus 2-bit force-format codes. Counts applied vectors, flags starvation, and signals completion on the vector marked last.

## Interface
- NPINS, 8: pins driven per vector
- DEPTH, 16: FIFO entries (power of two, ≥2)
- CLK  in  1  single clock
- RST  in  1  asynchronous, active-high reset
- START  in  1  one-clock pulse, begin run (ignored unless IDLE)
- STOP  in  1  one-clock pulse, abort run and flush FIFO
- CYCLE_LENGTH  in  8  clocks per tester cycle; 0 treated as 1
- VEC_VALID  in  1  host vector valid
- VEC_READY  out  1  FIFO can accept (not full, not in reset)
- VEC_DATA  in  NPINS  drive value per pin
- VEC_FF  in  2*NPINS  force format per pin (pin i at [2i+1:2i])
- VEC_LAST  in  1  final vector of pattern
- D_OUT  out  NPINS  applied drive values
- FF_OUT  out  2*NPINS  applied force formats
- EN_OUT  out  1  vector outputs valid / pin registers enabled
- BUSY  out  1  state ≠ IDLE
- DONE  out  1  one-clock pulse at normal completion
- UNDERRUN  out  1  sticky, FIFO empty at a cycle boundary
- VEC_COUNT  out  16  vectors applied this run, saturating at 0xFFFF

## Operation
- Push on VEC_VALID && VEC_READY; entry = {VEC_LAST, VEC_FF, VEC_DATA}.
- States: IDLE, PRIME, RUN, DONE.
- IDLE: outputs held; START → PRIME; clears UNDERRUN and VEC_COUNT.
- PRIME: wait for FIFO non-empty; pop → RUN, cycle counter = 1.
- RUN: counter 1..CYCLE_LENGTH. At counter == CYCLE_LENGTH (boundary):
  - applied vector had LAST → DONE.
  - else FIFO non-empty → pop, counter = 1, VEC_COUNT+1.
  - else underrun (see Configuration).
- DONE: EN_OUT low, DONE high one clock, → IDLE.
- STOP in any state: → IDLE next clock, FIFO flushed, EN_OUT low. STOP beats START in the same clock.
- FF code encoding: 00 R0, 01 R1, 10 DNRZ_L, 11 DNRZ_T. Passed through unchanged.
- Push and pop in the same clock are both honoured. Pop never happens when empty. VEC_READY is low when full, so push never happens when full.

## Timing
- Reset values: D_OUT 0, FF_OUT all 00 (R0), EN_OUT 0, BUSY 0, DONE 0, UNDERRUN 0, VEC_COUNT 0, VEC_READY 0. FIFO empty.
- VEC_READY goes high the first clock after RST deasserts, and is registered from the occupancy count.
- Pop clock N → D_OUT/FF_OUT updated and EN_OUT high at N+1 (one-clock latency). Outputs stay stable for exactly CYCLE_LENGTH clocks.
- A vector pushed into an empty FIFO in PRIME appears on outputs 2 clocks after the push handshake.
- BUSY rises the clock after START and falls the clock after DONE or STOP.
- CYCLE_LENGTH is sampled at each boundary. A mid-run change takes effect from the next vector.
- RST mid-run: immediate return to reset values. In-flight vectors are lost.

## Configuration
- VEC_SEQ_UNDERRUN_HOLD_EN defined: on underrun, hold the current vector for another tester cycle, set UNDERRUN, stay in RUN. VEC_COUNT does not increment for held cycles.
- Not defined: on underrun, set UNDERRUN and go to IDLE. EN_OUT drops the next clock and DONE is not pulsed.

## Structure
- Package vec_seq_pkg holds:
  - the state enum;
  - FF code constants FF_R0, FF_R1, FF_DNRZ_L, FF_DNRZ_T;
  - the reset FF value.
- Sub-module vec_fifo: synchronous FIFO, width 3*NPINS+1, depth DEPTH, with full/empty/count. The sequencer owns the cycle counter and the FSM.

## Test plan
- CYCLE_LENGTH=4; push 3 vectors (last on 3rd); START → EN_OUT for exactly 12 clocks, each vector held 4 clocks, DONE pulse once, VEC_COUNT=3.
- Push 16 vectors with no START → VEC_READY low after the 16th. The 17th VALID is not accepted and the FIFO contents are unchanged.
- START with empty FIFO, push 1 vector 10 clocks later → stays PRIME, outputs appear 2 clocks after the push.
- 2 vectors without LAST, CYCLE_LENGTH=3 → UNDERRUN=1 at the 2nd boundary. With HOLD_EN: vector 2 repeated, BUSY stays high. Without: IDLE, EN_OUT low, DONE 0.
- STOP and START in the same clock during RUN → IDLE, FIFO empty, VEC_READY high, no restart.
- RST asserted mid-vector → all outputs at reset values immediately; after release, a fresh run works normally.
